// File: rtl/missile_fire_ctrl_if.sv
// Missile fire controller bus: frame strobe, shoot key, mover handshake,
// collision input and HUD statistics for one tank's missile.
// master : the fire controller itself
// slave  : the surrounding mover / collision / HUD logic
interface missile_fire_ctrl_if;
  logic        startOfFrame;
  logic        keyRaw;
  logic [10:0] missileTopLeftX;
  logic [10:0] missileTopLeftY;
  logic        missileDrawEn;
  logic        hitCollision;
  logic        fireReq;
  logic        missileKill;
  logic        busy;
  logic [7:0]  shotCount;
  logic [7:0]  hitCount;
  logic        fireFail;

  modport master (
    input  startOfFrame, keyRaw, missileTopLeftX, missileTopLeftY,
           missileDrawEn, hitCollision,
    output fireReq, missileKill, busy, shotCount, hitCount, fireFail
  );

  modport slave (
    output startOfFrame, keyRaw, missileTopLeftX, missileTopLeftY,
           missileDrawEn, hitCollision,
    input  fireReq, missileKill, busy, shotCount, hitCount, fireFail
  );
endinterface

// File: rtl/missile_fire_ctrl.sv
// Fire-side controller for one tank's missile: turns the shoot key into a
// one-clock fire request, supervises the missile in flight (hit, off-screen,
// flight timeout), strobes the kill, enforces a frame-based reload cooldown
// and keeps saturating shot/hit counters for the HUD.
// Optional build macro AUTOFIRE_EN: when defined, a held key (level) also
// fires from IDLE, so the tank refires every time the cooldown ends.
module missile_fire_ctrl #(
  parameter int SCREEN_W          = 640,
  parameter int SCREEN_H          = 480,
  parameter int MISSILE_SIZE      = 8,
  parameter int MAX_FLIGHT_FRAMES = 90,
  parameter int COOLDOWN_FRAMES   = 15,
  parameter int ACK_TIMEOUT       = 4
) (
  input  logic                 clk,
  input  logic                 resetN,
  missile_fire_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FIRE     = 3'd1,
    FLIGHT   = 3'd2,
    KILL     = 3'd3,
    COOLDOWN = 3'd4
  } state_t;

  // Highest legal top-left coordinate; anything above (including wrapped
  // negative positions, which land near 2047) is off screen.
  localparam logic [10:0] X_MAX      = 11'(SCREEN_W - MISSILE_SIZE);
  localparam logic [10:0] Y_MAX      = 11'(SCREEN_H - MISSILE_SIZE);
  localparam logic [7:0]  FLIGHT_LIM = 8'(MAX_FLIGHT_FRAMES);
  localparam logic [7:0]  CD_LIM     = 8'(COOLDOWN_FRAMES);
  localparam logic [3:0]  ACK_LIM    = 4'(ACK_TIMEOUT);

  state_t     state;
  logic       keyPrev;
  logic [3:0] ackCnt;
  logic [7:0] frameCnt;
  logic [7:0] cdCnt;

  logic keyEdge;
  logic fireTrig;
  logic outOfBounds;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign keyEdge     = bus.keyRaw & ~keyPrev;
  assign outOfBounds = (bus.missileTopLeftX > X_MAX) || (bus.missileTopLeftY > Y_MAX);

`ifdef AUTOFIRE_EN
  assign fireTrig = keyEdge | bus.keyRaw;
`else
  assign fireTrig = keyEdge;
`endif

  // Fire/flight/kill/cooldown sequencer with registered outputs and counters.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state           <= IDLE;
      keyPrev         <= 1'b0;
      ackCnt          <= 4'd0;
      frameCnt        <= 8'd0;
      cdCnt           <= 8'd0;
      bus.fireReq     <= 1'b0;
      bus.missileKill <= 1'b0;
      bus.busy        <= 1'b0;
      bus.shotCount   <= 8'd0;
      bus.hitCount    <= 8'd0;
      bus.fireFail    <= 1'b0;
    end else begin
      keyPrev <= bus.keyRaw;
      case (state)
        IDLE: begin
          if (fireTrig) begin
            bus.fireReq <= 1'b1;
            bus.busy    <= 1'b1;
            ackCnt      <= 4'd0;
            state       <= FIRE;
          end
        end
        FIRE: begin
          bus.fireReq <= 1'b0;
          if (bus.missileDrawEn) begin
            frameCnt      <= 8'd0;
            bus.shotCount <= sat_inc8(bus.shotCount);
            state         <= FLIGHT;
          end else begin
            ackCnt <= ackCnt + 4'd1;
            if (ackCnt + 4'd1 == ACK_LIM) begin
              bus.fireFail <= 1'b1;
              bus.busy     <= 1'b0;
              state        <= IDLE;
            end
          end
        end
        FLIGHT: begin
          // Priority: external kill, hit, off-screen, flight timeout.
          if (!bus.missileDrawEn) begin
            cdCnt <= 8'd0;
            state <= COOLDOWN;
          end else if (bus.hitCollision) begin
            bus.hitCount    <= sat_inc8(bus.hitCount);
            bus.missileKill <= 1'b1;
            state           <= KILL;
          end else if (outOfBounds) begin
            bus.missileKill <= 1'b1;
            state           <= KILL;
          end else if (bus.startOfFrame) begin
            frameCnt <= frameCnt + 8'd1;
            if (frameCnt + 8'd1 == FLIGHT_LIM) begin
              bus.missileKill <= 1'b1;
              state           <= KILL;
            end
          end
        end
        KILL: begin
          // Hold the kill until the mover confirms the missile is gone.
          if (!bus.missileDrawEn) begin
            bus.missileKill <= 1'b0;
            cdCnt           <= 8'd0;
            state           <= COOLDOWN;
          end
        end
        COOLDOWN: begin
          if (cdCnt == CD_LIM) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else if (bus.startOfFrame) begin
            cdCnt <= cdCnt + 8'd1;
          end
        end
        default: begin
          bus.fireReq     <= 1'b0;
          bus.missileKill <= 1'b0;
          bus.busy        <= 1'b0;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_missile_fire_ctrl.sv
// Testbench for missile_fire_ctrl: scenario tasks plus a randomized
// shot-by-shot reference model of launches, flight endings and cooldowns.
module tb_missile_fire_ctrl;

  localparam int MAXF = 90;
  localparam int CDF  = 15;

  logic clk    = 1'b0;
  logic resetN = 1'b0;

  int checks    = 0;
  int errors    = 0;
  int exp_shots = 0;
  int exp_hits  = 0;

  missile_fire_ctrl_if bus ();

  missile_fire_ctrl #(
    .SCREEN_W(640), .SCREEN_H(480), .MISSILE_SIZE(8),
    .MAX_FLIGHT_FRAMES(MAXF), .COOLDOWN_FRAMES(CDF), .ACK_TIMEOUT(4)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    tick();
  endtask

  task automatic press_key();
    bus.keyRaw = 1'b1;
    tick();
    bus.keyRaw = 1'b0;
  endtask

  // Key press, mover acknowledges after d extra clocks.
  task automatic launch(input int d);
    press_key();
    repeat (d) tick();
    bus.missileDrawEn = 1'b1;
    tick();
  endtask

  // Pulse frames until busy drops; returns the number of frames (-1 on timeout).
  task automatic run_cooldown(output int n);
    n = -1;
    for (int f = 0; f <= 40; f++) begin
      if (bus.busy === 1'b0) begin
        n = f;
        break;
      end
      frame();
    end
  endtask

  task automatic do_reset();
    resetN               = 1'b0;
    bus.keyRaw           = 1'b0;
    bus.startOfFrame     = 1'b0;
    bus.hitCollision     = 1'b0;
    bus.missileDrawEn    = 1'b0;
    bus.missileTopLeftX  = 11'd100;
    bus.missileTopLeftY  = 11'd100;
    repeat (3) tick();
    resetN = 1'b1;
    tick();
    exp_shots = 0;
    exp_hits  = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.fireReq, bus.missileKill, bus.busy, bus.fireFail, bus.shotCount, bus.hitCount} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {bus.fireReq, bus.missileKill, bus.busy, bus.fireFail, bus.shotCount, bus.hitCount});
    end
  endtask

  task automatic test_fire_hit();
    int n;
    press_key();
    checks++;
    if (bus.fireReq !== 1'b1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL fire_pulse_on: fireReq=%b busy=%b required 1 1", bus.fireReq, bus.busy);
    end
    tick();
    checks++;
    if (bus.fireReq !== 1'b0) begin
      errors++; $display("FAIL fire_pulse_off: fireReq=%b required 0", bus.fireReq);
    end
    bus.missileDrawEn = 1'b1;
    tick();
    exp_shots++;
    checks++;
    if (bus.shotCount !== 8'(exp_shots) || bus.busy !== 1'b1) begin
      errors++; $display("FAIL launch_shots: shotCount=%0d busy=%b required %0d 1", bus.shotCount, bus.busy, exp_shots);
    end
    bus.hitCollision = 1'b1;
    tick();
    bus.hitCollision = 1'b0;
    exp_hits++;
    checks++;
    if (bus.missileKill !== 1'b1 || bus.hitCount !== 8'(exp_hits)) begin
      errors++; $display("FAIL hit_kill: kill=%b hitCount=%0d required 1 %0d", bus.missileKill, bus.hitCount, exp_hits);
    end
    bus.missileDrawEn = 1'b0;
    tick();
    checks++;
    if (bus.missileKill !== 1'b0) begin
      errors++; $display("FAIL kill_release: kill=%b required 0", bus.missileKill);
    end
    repeat (14) frame();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL cooldown_14: busy=%b required 1", bus.busy);
    end
    frame();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL cooldown_15: busy=%b required 0", bus.busy);
    end
    n = 0;
  endtask

  task automatic test_out_of_bounds();
    int n;
    launch(1);
    exp_shots++;
    bus.missileTopLeftX = 11'd632;
    tick();
    checks++;
    if (bus.missileKill !== 1'b0) begin
      errors++; $display("FAIL x_edge_inbounds: kill=%b required 0", bus.missileKill);
    end
    bus.missileTopLeftX = 11'd633;
    tick();
    checks++;
    if (bus.missileKill !== 1'b1 || bus.hitCount !== 8'(exp_hits)) begin
      errors++; $display("FAIL x_oob_kill: kill=%b hitCount=%0d required 1 %0d", bus.missileKill, bus.hitCount, exp_hits);
    end
    bus.missileDrawEn = 1'b0;
    tick();
    bus.missileTopLeftX = 11'd100;
    run_cooldown(n);
    checks++;
    if (n != CDF) begin
      errors++; $display("FAIL x_oob_cooldown: frames=%0d required %0d", n, CDF);
    end
    launch(0);
    exp_shots++;
    bus.missileTopLeftY = 11'd2047;
    tick();
    checks++;
    if (bus.missileKill !== 1'b1 || bus.shotCount !== 8'(exp_shots)) begin
      errors++; $display("FAIL y_wrap_kill: kill=%b shotCount=%0d required 1 %0d", bus.missileKill, bus.shotCount, exp_shots);
    end
    bus.missileDrawEn = 1'b0;
    tick();
    bus.missileTopLeftY = 11'd100;
    run_cooldown(n);
  endtask

  task automatic test_flight_timeout();
    int n;
    launch(2);
    exp_shots++;
    repeat (MAXF - 1) frame();
    checks++;
    if (bus.missileKill !== 1'b0) begin
      errors++; $display("FAIL timeout_early: kill=%b required 0 after %0d frames", bus.missileKill, MAXF - 1);
    end
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    checks++;
    if (bus.missileKill !== 1'b1) begin
      errors++; $display("FAIL timeout_kill: kill=%b required 1", bus.missileKill);
    end
    bus.missileDrawEn = 1'b0;
    tick();
    run_cooldown(n);
  endtask

  task automatic test_fire_fail();
    press_key();
    repeat (3) tick();
    checks++;
    if (bus.fireFail !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL ack_wait: fireFail=%b busy=%b required 0 1", bus.fireFail, bus.busy);
    end
    tick();
    checks++;
    if (bus.fireFail !== 1'b1 || bus.busy !== 1'b0 || bus.shotCount !== 8'(exp_shots)) begin
      errors++; $display("FAIL ack_timeout: fireFail=%b busy=%b shotCount=%0d required 1 0 %0d",
                         bus.fireFail, bus.busy, bus.shotCount, exp_shots);
    end
  endtask

  task automatic test_key_dropped();
    int n;
    launch(1);
    exp_shots++;
    press_key();
    checks++;
    if (bus.fireReq !== 1'b0) begin
      errors++; $display("FAIL key_in_flight: fireReq=%b required 0", bus.fireReq);
    end
    bus.missileDrawEn = 1'b0;
    tick();
    checks++;
    if (bus.missileKill !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL external_drop: kill=%b busy=%b required 0 1", bus.missileKill, bus.busy);
    end
    press_key();
    checks++;
    if (bus.fireReq !== 1'b0) begin
      errors++; $display("FAIL key_in_cooldown: fireReq=%b required 0", bus.fireReq);
    end
    run_cooldown(n);
    checks++;
    if (n != CDF || bus.fireFail !== 1'b1 || bus.shotCount !== 8'(exp_shots)) begin
      errors++; $display("FAIL drop_cooldown: frames=%0d fireFail=%b shotCount=%0d required %0d 1 %0d",
                         n, bus.fireFail, bus.shotCount, CDF, exp_shots);
    end
  endtask

  task automatic test_random();
    int n, d, nfr, kind, f;
    for (int s = 0; s < 30; s++) begin
      d = $urandom_range(0, 3);
      launch(d);
      exp_shots++;
      checks++;
      if (bus.shotCount !== 8'(exp_shots)) begin
        errors++; $display("FAIL rnd_shots: shot %0d shotCount=%0d required %0d", s, bus.shotCount, exp_shots);
      end
      nfr = $urandom_range(0, 6);
      for (int i = 0; i < nfr; i++) begin
        bus.missileTopLeftX = 11'($urandom_range(0, 632));
        bus.missileTopLeftY = 11'($urandom_range(0, 472));
        if ($urandom_range(0, 3) == 0) begin
          press_key();
          checks++;
          if (bus.fireReq !== 1'b0) begin
            errors++; $display("FAIL rnd_stray_key: shot %0d fireReq=%b required 0", s, bus.fireReq);
          end
        end
        frame();
      end
      kind = $urandom_range(0, 4);
      case (kind)
        0: begin
          bus.hitCollision = 1'b1;
          if ($urandom_range(0, 1) == 1) bus.missileTopLeftX = 11'($urandom_range(633, 2047));
          bus.startOfFrame = 1'($urandom_range(0, 1));
          tick();
          bus.hitCollision = 1'b0;
          bus.startOfFrame = 1'b0;
          exp_hits++;
        end
        1: begin
          bus.missileTopLeftX = 11'($urandom_range(633, 2047));
          tick();
        end
        2: begin
          bus.missileTopLeftY = 11'($urandom_range(473, 2047));
          tick();
        end
        3: begin
          bus.missileDrawEn = 1'b0;
          tick();
        end
        default: begin
          f = nfr;
          while (bus.missileKill !== 1'b1 && f < 200) begin
            bus.startOfFrame = 1'b1;
            tick();
            bus.startOfFrame = 1'b0;
            f++;
            if (bus.missileKill !== 1'b1) tick();
          end
          checks++;
          if (f != MAXF) begin
            errors++; $display("FAIL rnd_timeout: shot %0d killed after %0d frames required %0d", s, f, MAXF);
          end
        end
      endcase
      if (kind == 3) begin
        checks++;
        if (bus.missileKill !== 1'b0 || bus.busy !== 1'b1) begin
          errors++; $display("FAIL rnd_drop: shot %0d kill=%b busy=%b required 0 1", s, bus.missileKill, bus.busy);
        end
      end else begin
        checks++;
        if (bus.missileKill !== 1'b1) begin
          errors++; $display("FAIL rnd_kill: shot %0d kind %0d kill=%b required 1", s, kind, bus.missileKill);
        end
        bus.missileDrawEn = 1'b0;
        tick();
      end
      checks++;
      if (bus.hitCount !== 8'(exp_hits) || bus.missileKill !== 1'b0) begin
        errors++; $display("FAIL rnd_hits: shot %0d hitCount=%0d kill=%b required %0d 0", s, bus.hitCount, bus.missileKill, exp_hits);
      end
      bus.missileTopLeftX = 11'd100;
      bus.missileTopLeftY = 11'd100;
      run_cooldown(n);
      checks++;
      if (n != CDF) begin
        errors++; $display("FAIL rnd_cooldown: shot %0d frames=%0d required %0d", s, n, CDF);
      end
    end
  endtask

  task automatic test_saturation();
    int n;
    do_reset();
    for (int s = 0; s < 256; s++) begin
      launch(0);
      bus.hitCollision = 1'b1;
      tick();
      bus.hitCollision = 1'b0;
      bus.missileDrawEn = 1'b0;
      tick();
      run_cooldown(n);
      if (exp_shots < 255) exp_shots++;
      if (exp_hits < 255) exp_hits++;
    end
    checks++;
    if (bus.shotCount !== 8'(exp_shots) || bus.hitCount !== 8'(exp_hits)) begin
      errors++; $display("FAIL saturate: shotCount=%0d hitCount=%0d required %0d %0d",
                         bus.shotCount, bus.hitCount, exp_shots, exp_hits);
    end
  endtask

  task automatic test_held_key();
    int fires, age;
    do_reset();
    fires = 0;
    age   = 0;
    bus.keyRaw = 1'b1;
    for (int c = 0; c < 400; c++) begin
      bus.startOfFrame = ((c % 2) == 0);
      tick();
      if (bus.fireReq === 1'b1) begin
        fires++;
        bus.missileDrawEn = 1'b1;
        age = 0;
      end else if (bus.missileDrawEn === 1'b1) begin
        age++;
        if (age == 6) bus.missileDrawEn = 1'b0;
      end
    end
    bus.keyRaw       = 1'b0;
    bus.startOfFrame = 1'b0;
    checks++;
`ifdef AUTOFIRE_EN
    if (fires < 2 || bus.shotCount !== 8'(fires)) begin
      errors++; $display("FAIL held_key_autofire: fires=%0d shotCount=%0d required >=2 and equal", fires, bus.shotCount);
    end
`else
    if (fires != 1 || bus.shotCount !== 8'd1) begin
      errors++; $display("FAIL held_key_single: fires=%0d shotCount=%0d required 1 1", fires, bus.shotCount);
    end
`endif
  endtask

  task automatic test_reset_mid_flight();
    do_reset();
    press_key();
    repeat (4) tick();
    launch(0);
    frame();
    checks++;
    if (bus.busy !== 1'b1 || bus.shotCount !== 8'd1 || bus.fireFail !== 1'b1) begin
      errors++; $display("FAIL pre_reset_flight: busy=%b shotCount=%0d fireFail=%b required 1 1 1",
                         bus.busy, bus.shotCount, bus.fireFail);
    end
    resetN = 1'b0;
    tick();
    checks++;
    if ({bus.fireReq, bus.missileKill, bus.busy, bus.fireFail, bus.shotCount, bus.hitCount} !== 20'h0) begin
      errors++; $display("FAIL reset_mid_flight: got %h required 0",
                         {bus.fireReq, bus.missileKill, bus.busy, bus.fireFail, bus.shotCount, bus.hitCount});
    end
    bus.missileDrawEn = 1'b0;
    resetN = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fire_hit();
    test_out_of_bounds();
    test_flight_timeout();
    test_fire_fail();
    test_key_dropped();
    test_random();
    test_saturation();
    test_held_key();
    test_reset_mid_flight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
